// File: rtl/argmax_frame_sequencer_if.sv
// argmax_frame_sequencer_if: chunk input stream and result output stream of the argmax sequencer.
// The sequencer takes the slave modport; the chunk producer / result consumer side takes master.
interface argmax_frame_sequencer_if #(
    parameter int WIDTH       = 8,
    parameter int LANES       = 16,
    parameter int INDEX_WIDTH = 8
);
    logic                   in_valid;
    logic                   in_ready;
    logic [LANES*WIDTH-1:0] in;
    logic                   out_valid;
    logic                   out_ready;
    logic [WIDTH-1:0]       max;
    logic [INDEX_WIDTH-1:0] argmax;

    modport master (
        output in_valid, in, out_ready,
        input  in_ready, out_valid, max, argmax
    );

    modport slave (
        input  in_valid, in, out_ready,
        output in_ready, out_valid, max, argmax
    );
endinterface

// File: rtl/argmax_frame_sequencer.sv
// argmax_frame_sequencer: signed argmax over a frame of num_chunks chunks of LANES lanes each.
// Define ARGMAX_FRAME_SEQUENCER_ABORT_EN to add the abort input that drops a frame in RUN/DONE.
module argmax_frame_sequencer #(
    parameter int WIDTH       = 8,
    parameter int LANES       = 16,
    parameter int INDEX_WIDTH = 8,
    parameter int CHUNK_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [CHUNK_WIDTH-1:0] num_chunks,
`ifdef ARGMAX_FRAME_SEQUENCER_ABORT_EN
    input  logic                   abort,
`endif
    output logic                   busy,
    argmax_frame_sequencer_if.slave bus
);
    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int GW = CHUNK_WIDTH + LW;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                  state_q, state_d;
    logic [CHUNK_WIDTH-1:0]  cnt_q, cnt_d, len_q, len_d;
    logic signed [WIDTH-1:0] max_q, max_d, cmax;
    logic [INDEX_WIDTH-1:0]  arg_q, arg_d;
    logic [LW-1:0]           clane;
    logic [GW-1:0]           gidx;
    logic                    abort_i, accept, hs, last, upd;

`ifdef ARGMAX_FRAME_SEQUENCER_ABORT_EN
    assign abort_i = abort;
`else
    assign abort_i = 1'b0;
`endif

    // Strict greater-than while scanning upward keeps the lowest lane on ties.
    always_comb begin
        cmax  = $signed(bus.in[WIDTH-1:0]);
        clane = '0;
        for (int i = 1; i < LANES; i++) begin
            clane = ($signed(bus.in[i*WIDTH +: WIDTH]) > cmax) ? LW'(i) : clane;
            cmax  = ($signed(bus.in[i*WIDTH +: WIDTH]) > cmax) ? $signed(bus.in[i*WIDTH +: WIDTH]) : cmax;
        end
    end

    assign gidx   = GW'(cnt_q) * GW'(LANES) + GW'(clane);
    assign accept = (state_q == IDLE) && start && (num_chunks != '0);
    assign hs     = bus.in_valid && (state_q == RUN) && !abort_i;
    assign last   = cnt_q == len_q - CHUNK_WIDTH'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            max_q   <= '0;
            arg_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            max_q   <= max_d;
            arg_q   <= arg_d;
        end
    end

    always_comb begin
        state_d = (abort_i && state_q != IDLE) ? IDLE :
                  (state_q == IDLE) ? (accept ? RUN : IDLE) :
                  (state_q == RUN)  ? ((hs && last) ? DONE : RUN) :
                  bus.out_ready ? IDLE : DONE;
        len_d   = accept ? num_chunks : len_q;
        cnt_d   = accept ? '0 : hs ? cnt_q + CHUNK_WIDTH'(1) : cnt_q;
        // First chunk of a frame loads unconditionally so stale results never leak in.
        upd     = hs && (cnt_q == '0 || cmax > max_q);
        max_d   = upd ? cmax : max_q;
        arg_d   = upd ? INDEX_WIDTH'(gidx) : arg_q;
    end

    always_comb begin
        busy          = state_q != IDLE;
        bus.in_ready  = state_q == RUN;
        bus.out_valid = state_q == DONE;
        bus.max       = max_q;
        bus.argmax    = arg_q;
    end
endmodule

// File: doc/argmax_frame_sequencer.md
Name: argmax_frame_sequencer

Overview:
- Frame-level controller for the signed serial-parallel argmax datapath.
- Accepts a frame of `num_chunks` chunks, each LANES signed values wide, over a valid/ready input stream.
- Tracks the running maximum and its global index across chunks, then presents one result on a valid/ready output.
- Sits between a feature/logit buffer and the classifier decision logic; sequences argmax over vectors longer than the lane count.

Parameters:
- WIDTH, 8, bit width of each signed element and of `max`.
- LANES, 16, elements per chunk (parallel comparator lanes).
- INDEX_WIDTH, 8, width of `argmax`.
- CHUNK_WIDTH, 4, width of `num_chunks` and of the internal chunk counter.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset asserted).
- start  input  1  one-cycle frame start request; honoured only in IDLE.
- num_chunks  input  CHUNK_WIDTH  chunks in the frame; sampled on accepted start.
- busy  output  1  high in RUN and DONE.
- in_valid  input  1  chunk present on `in`.
- in_ready  output  1  sequencer accepts a chunk this cycle.
- in  input  LANES x WIDTH  packed signed lanes; lane i is element i of the chunk.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- max  output  WIDTH  signed maximum of the frame.
- argmax  output  INDEX_WIDTH  global index of `max`.

Behaviour:
- Reset values: `busy`, `in_ready`, `out_valid`, `max` and `argmax` all 0; state IDLE; chunk counter 0. Reset mid-frame discards the partial result.
- States:
  - IDLE → RUN on `start` with `num_chunks` ≠ 0; latch `num_chunks`; clear the counter.
  - `start` with `num_chunks` = 0 is ignored; state stays IDLE.
  - RUN: `in_ready` = 1. Each handshake (`in_valid` & `in_ready`) processes one chunk. After the chunk where counter = latched − 1 is accepted → DONE.
  - DONE: `out_valid` = 1, `in_ready` = 0. On `out_ready` → IDLE.
- `start` in RUN or DONE is ignored; `num_chunks` changes after latching are ignored.
- Chunk reduction (combinational, signed compare):
  - Chunk max is the largest lane value.
  - On ties, the lowest lane index wins.
- Running update on each handshake:
  - First chunk of a frame loads unconditionally.
  - Later chunks replace the running value only if chunk max > running max (strict), so the earliest global index wins on ties.
- Global index = counter × LANES + lane, computed at full width, then truncated to INDEX_WIDTH (wraps silently; integrator sizes INDEX_WIDTH).
- Latency: `out_valid` rises the cycle after the final chunk handshake.
- `max` and `argmax` hold stable while `out_valid` = 1 and `out_ready` = 0. They keep their last value in IDLE until the next frame's first chunk.
- Gaps in `in_valid` stall the sequencer with no state change.
- Same-cycle DONE→IDLE and a new `start`: the start is ignored (not in IDLE that cycle).

Optional Feature:
- Macro: ARGMAX_FRAME_SEQUENCER_ABORT_EN.
- Defined:
  - Adds input port `abort` (1 bit).
  - `abort` high in RUN or DONE → IDLE on the next edge, with no `out_valid` pulse for that frame.
  - `in_ready` and `out_valid` drop that edge; `max`/`argmax` retain their values.
  - `abort` in IDLE has no effect; `abort` has priority over a simultaneous handshake.
- Undefined: no `abort` port; a frame can only be terminated by completion or reset.

Test Plan:
- Reset: hold `rst` = 0 for 2 cycles with random inputs → `busy`/`in_ready`/`out_valid`/`max`/`argmax` all 0. Release → IDLE; `in_ready` = 0 even with `in_valid` = 1.
- Single chunk: `num_chunks` = 1, lane i = i − 8 → one cycle after the handshake `out_valid` = 1, `max` = 7, `argmax` = 15.
- Multi-chunk with gaps: `num_chunks` = 3, chunk c lane i = c + i, `in_valid` low 2 cycles between chunks → `max` = 17, `argmax` = 47.
- Ties and negatives:
  - `num_chunks` = 2, all lanes −5 → `max` = −5, `argmax` = 0.
  - Then all lanes −128 except chunk 1 lane 3 = −127 → `max` = −127, `argmax` = 19.
- Backpressure: hold `out_ready` = 0 for 5 cycles after DONE and pulse `start` → outputs stable, `start` ignored. Raise `out_ready` → IDLE the next cycle; a new `start` is accepted.
- Reset mid-frame: `num_chunks` = 4, assert `rst` after 2 chunks → outputs 0 immediately. After release, run the single-chunk test → `max` = 7, `argmax` = 15 (no stale state).
